// File: rtl/level_qualifier.sv
// level_qualifier: multi-channel qualifier for asynchronous ready-type inputs.
// A channel's ready asserts after ASSERT_CYCLES consecutive high samples.
// It deasserts after DEASSERT_CYCLES consecutive low samples.
// Shorter low runs while ready is high are counted as glitches
// (saturating 8-bit counter per channel).
// Optional macro LEVEL_QUAL_SYNC_EN: puts a 2-flop synchroniser in front of
// each channel, which adds 2 cycles to both the assert and deassert latency.

module level_qualifier_ch #(
    parameter int ASSERT_CYCLES   = 1000,
    parameter int DEASSERT_CYCLES = 1,
    parameter int CNT_W           = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s,
    input  logic       clr_glitch,
    output logic       ready,
    output logic       rise,
    output logic       fall,
    output logic [7:0] glitch_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] QUAL  = 2'd1;
    localparam logic [1:0] READY = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam logic [CNT_W-1:0] ASSERT_LAST   = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEASSERT_LAST = CNT_W'(DEASSERT_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    // Qualification FSM; ready/rise/fall are registered with the state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ready <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        if (ASSERT_CYCLES == 1) begin
                            state <= READY;
                            ready <= 1'b1;
                            rise  <= 1'b1;
                        end else begin
                            state <= QUAL;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                QUAL: begin
                    if (!s) begin
                        // Any low sample discards the partial qualification.
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == ASSERT_LAST) begin
                        state <= READY;
                        cnt   <= '0;
                        ready <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                READY: begin
                    if (!s) begin
                        if (DEASSERT_CYCLES == 1) begin
                            state <= IDLE;
                            ready <= 1'b0;
                            fall  <= 1'b1;
                        end else begin
                            state <= HOLD;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                default: begin // HOLD
                    if (s) begin
                        state <= READY;
                        cnt   <= '0;
                    end else if (cnt == DEASSERT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        ready <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Glitch counter: a HOLD that recovers is a glitch; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst || clr_glitch)
            glitch_cnt <= 8'd0;
        else if (state == HOLD && s && glitch_cnt != 8'hFF)
            glitch_cnt <= glitch_cnt + 8'd1;
    end

endmodule

module level_qualifier #(
    parameter int NUM_CH          = 4,
    parameter int ASSERT_CYCLES   = 1000,
    parameter int DEASSERT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     in,
    input  logic                  clr_glitch,
    output logic [NUM_CH-1:0]     ready,
    output logic [NUM_CH-1:0]     rise,
    output logic [NUM_CH-1:0]     fall,
    output logic [8*NUM_CH-1:0]   glitch_cnt,
    output logic                  all_ready
);

    localparam int MAX_CYC = (ASSERT_CYCLES > DEASSERT_CYCLES) ? ASSERT_CYCLES : DEASSERT_CYCLES;
    localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    generate
        if (NUM_CH < 1 || ASSERT_CYCLES < 1 || DEASSERT_CYCLES < 1) begin : g_bad_param
            $error("level_qualifier: NUM_CH, ASSERT_CYCLES and DEASSERT_CYCLES must all be >= 1");
        end
    endgenerate

    logic [NUM_CH-1:0] s_lvl;

`ifdef LEVEL_QUAL_SYNC_EN
    logic [NUM_CH-1:0] sync1, sync2;

    // Two-flop synchroniser for asynchronous board-level inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
        end
    end

    assign s_lvl = sync2;
`else
    assign s_lvl = in;
`endif

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            level_qualifier_ch #(
                .ASSERT_CYCLES   (ASSERT_CYCLES),
                .DEASSERT_CYCLES (DEASSERT_CYCLES),
                .CNT_W           (CNT_W)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .s          (s_lvl[i]),
                .clr_glitch (clr_glitch),
                .ready      (ready[i]),
                .rise       (rise[i]),
                .fall       (fall[i]),
                .glitch_cnt (glitch_cnt[8*i +: 8])
            );
        end
    endgenerate

    assign all_ready = &ready;

endmodule

// File: tb/tb_level_qualifier.sv
// Scoreboard bench for level_qualifier (NUM_CH=2, ASSERT=4, DEASSERT=3).
// A run-length reference model predicts every output after each clock.
module tb_level_qualifier;

    localparam int NCH = 2;
    localparam int A   = 4;
    localparam int D   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    in;
    logic              clr_glitch;
    logic [NCH-1:0]    ready, rise, fall;
    logic [8*NCH-1:0]  glitch_cnt;
    logic              all_ready;

    always #5 clk = ~clk;

    level_qualifier #(
        .NUM_CH          (NCH),
        .ASSERT_CYCLES   (A),
        .DEASSERT_CYCLES (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .clr_glitch (clr_glitch),
        .ready      (ready),
        .rise       (rise),
        .fall       (fall),
        .glitch_cnt (glitch_cnt),
        .all_ready  (all_ready)
    );

    typedef struct {
        logic [NCH-1:0]   ready;
        logic [NCH-1:0]   rise;
        logic [NCH-1:0]   fall;
        logic [8*NCH-1:0] glitch;
        logic             all;
    } exp_t;

    exp_t sbq[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: consecutive high/low run lengths per channel.
    int             hi_run [NCH];
    int             lo_run [NCH];
    logic [7:0]     m_g    [NCH];
    logic [NCH-1:0] m_ready = '0;
    logic [NCH-1:0] m_s1 = '0, m_s2 = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Predict the post-edge outputs for the given inputs.
    task automatic model(input logic r, input logic [NCH-1:0] v, input logic c);
        exp_t e;
        logic [NCH-1:0] s;
        e.rise = '0;
        e.fall = '0;
        if (r) begin
            m_ready = '0;
            m_s1 = '0;
            m_s2 = '0;
            for (int i = 0; i < NCH; i++) begin
                hi_run[i] = 0; lo_run[i] = 0; m_g[i] = 8'd0;
            end
        end else begin
`ifdef LEVEL_QUAL_SYNC_EN
            s = m_s2; m_s2 = m_s1; m_s1 = v;
`else
            s = v;
`endif
            for (int i = 0; i < NCH; i++) begin
                if (!m_ready[i]) begin
                    hi_run[i] = s[i] ? hi_run[i] + 1 : 0;
                    if (hi_run[i] == A) begin
                        m_ready[i] = 1'b1; e.rise[i] = 1'b1; hi_run[i] = 0; lo_run[i] = 0;
                    end
                end else if (!s[i]) begin
                    lo_run[i]++;
                    if (lo_run[i] == D) begin
                        m_ready[i] = 1'b0; e.fall[i] = 1'b1; lo_run[i] = 0; hi_run[i] = 0;
                    end
                end else begin
                    if (lo_run[i] > 0 && m_g[i] != 8'hFF) m_g[i] = m_g[i] + 8'd1;
                    lo_run[i] = 0;
                end
                if (c) m_g[i] = 8'd0;
            end
        end
        e.ready = m_ready;
        for (int i = 0; i < NCH; i++) e.glitch[8*i +: 8] = m_g[i];
        e.all = &m_ready;
        sbq.push_back(e);
    endtask

    task automatic step(input logic r, input logic [NCH-1:0] v, input logic c);
        exp_t e;
        rst = r;
        in = v;
        clr_glitch = c;
        model(r, v, c);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            chk("ready", 32'(ready), 32'(e.ready));
            chk("rise", 32'(rise), 32'(e.rise));
            chk("fall", 32'(fall), 32'(e.fall));
            chk("glitch_cnt", 32'(glitch_cnt), 32'(e.glitch));
            chk("all_ready", 32'(all_ready), 32'(e.all));
        end
    endtask

    task automatic glitch1(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 2'b00, 1'b0);
            step(1'b0, 2'b00, 1'b0);
            step(1'b0, 2'b10, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin hi_run[i] = 0; lo_run[i] = 0; m_g[i] = 8'd0; end
        rst = 1'b1; in = '0; clr_glitch = 1'b0;

        // Reset held 10 cycles.
        repeat (10) step(1'b1, 2'b00, 1'b0);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_glitch", 32'(glitch_cnt), 32'd0);

        // ch0 qualifies alone, then ch1 joins -> all_ready.
        repeat (6) step(1'b0, 2'b01, 1'b0);
        repeat (5) step(1'b0, 2'b11, 1'b0);

        // Drop both, then broken pattern 1,1,1,0,1,1,1,1 on ch0.
        repeat (4) step(1'b0, 2'b00, 1'b0);
        foreach (in[j]) ;
        step(1'b0, 2'b01, 1'b0); step(1'b0, 2'b01, 1'b0); step(1'b0, 2'b01, 1'b0);
        step(1'b0, 2'b00, 1'b0);
        repeat (4) step(1'b0, 2'b01, 1'b0);
        chk("requal_ready0", 32'(ready[0]), 32'd1);

        // Glitch 0,0,1 on ch0, then a real drop 0,0,0.
        step(1'b0, 2'b00, 1'b0); step(1'b0, 2'b00, 1'b0); step(1'b0, 2'b01, 1'b0);
        repeat (4) step(1'b0, 2'b00, 1'b0);

        // ch1: qualify, then saturate its glitch counter.
        repeat (5) step(1'b0, 2'b10, 1'b0);
        glitch1(300);
        chk("glitch_sat", 32'(glitch_cnt[15:8]), 32'd255);

        // Clear alone, one glitch, then clear landing on the increment edge.
        step(1'b0, 2'b10, 1'b1);
        glitch1(1);
        step(1'b0, 2'b00, 1'b0); step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b10, 1'b1);
        chk("clr_wins", 32'(glitch_cnt[15:8]), 32'd0);

        // Reset pulse while both ready with inputs held high.
        repeat (8) step(1'b0, 2'b11, 1'b0);
        step(1'b1, 2'b11, 1'b0);
        chk("rst_no_fall", 32'(fall), 32'd0);
        repeat (8) step(1'b0, 2'b11, 1'b0);

        while (sbq.size() != 0) void'(sbq.pop_front());
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
